// File: rtl/ysyx_22050612_pkg.sv
// rtl/ysyx_22050612_pkg.sv - shared state encoding and defaults for the fetch stage
package ysyx_22050612_pkg;

  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
  localparam int          IFU_ADDR_W   = 64;
  localparam int          IFU_INST_W   = 32;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/ysyx_22050612_if.sv
// rtl/ysyx_22050612_if.sv - instruction memory request/response channel
interface ysyx_22050612_if
  import ysyx_22050612_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W,
  parameter int INST_W = IFU_INST_W
) ();

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              imem_resp_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err
  );

endinterface

// File: rtl/ysyx_22050612_pc_reg.sv
// rtl/ysyx_22050612_pc_reg.sv - architectural PC, redirect beats increment beats hold
module ysyx_22050612_pc_reg
  import ysyx_22050612_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      // targets are word aligned; low bits of dnpc are dropped
      pc <= redirect_pc & ~ADDR_W'(3);
    end else if (inc) begin
      pc <= pc + ADDR_W'(4);
    end
  end

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// rtl/ysyx_22050612_ifu.sv - single-outstanding instruction fetch with redirect squash
module ysyx_22050612_ifu
  import ysyx_22050612_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter int                INST_W   = IFU_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_22050612_if.master       imem,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_W-1:0]     inst,
  output logic [ADDR_W-1:0]     inst_pc,
  output logic                  inst_fault,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc
);

  ifu_state_t        state, state_nxt;
  logic              kill, kill_nxt;
  logic              capture;
  logic              pc_inc;
  logic              req_fire;
  logic [ADDR_W-1:0] pc;

  ysyx_22050612_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect_valid),
    .redirect_pc (redirect_pc),
    .inc         (pc_inc),
    .pc          (pc)
  );

  assign imem.imem_req_valid = (state == REQ) && !rst;
  assign imem.imem_req_addr  = pc;
  assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;
  assign inst_valid          = (state == HOLD);

  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    capture   = 1'b0;
    pc_inc    = 1'b0;
    case (state)
      REQ: begin
        // a redirect racing the handshake leaves a stale fetch in flight
        if (req_fire) begin
          state_nxt = WAIT;
          kill_nxt  = redirect_valid;
        end
      end
      WAIT: begin
        if (imem.imem_resp_valid) begin
          state_nxt = REQ;
          kill_nxt  = 1'b0;
          if (!kill && !redirect_valid) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          kill_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_nxt = REQ;
        end else if (inst_ready) begin
          state_nxt = REQ;
          pc_inc    = 1'b1;
        end
      end
      default: begin
        state_nxt = REQ;
        kill_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      kill       <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      if (capture) begin
        inst       <= imem.imem_resp_data;
        inst_pc    <= pc;
        inst_fault <= imem.imem_resp_err;
      end
    end
  end

endmodule
